// File: rtl/game_level_sequencer_if.sv
// Bundle between the game-flow sequencer, the collision/renderer side and the motion datapath.
interface game_level_sequencer_if;
    logic       tick;
    logic       start;
    logic       hit_lava;
    logic       hit_exit;
    logic       hit_ckpt;
    logic [9:0] xpos;
    logic [9:0] ypos;
    logic [2:0] level;
    logic [2:0] lives;
    logic       freeze;
    logic       load_spawn;
    logic [9:0] spawn_x;
    logic [9:0] spawn_y;
    logic [5:0] sink_ofs;
    logic       win;
    logic       game_over;

    modport master (
        output tick, start, hit_lava, hit_exit, hit_ckpt, xpos, ypos,
        input  level, lives, freeze, load_spawn, spawn_x, spawn_y, sink_ofs, win, game_over
    );

    modport slave (
        input  tick, start, hit_lava, hit_exit, hit_ckpt, xpos, ypos,
        output level, lives, freeze, load_spawn, spawn_x, spawn_y, sink_ofs, win, game_over
    );
endinterface

// File: rtl/game_level_sequencer.sv
// Game-flow controller: level, lives, spawn point and motion freeze.
// Optional CHECKPOINT_EN: checkpoint tiles capture the respawn position.
module game_level_sequencer #(
    parameter int NUM_LEVELS   = 4,
    parameter int LIVES        = 3,
    parameter int SPAWN_X      = 304,
    parameter int SPAWN_Y      = 220,
    parameter int DEATH_FRAMES = 32,
    parameter int TRANS_FRAMES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    game_level_sequencer_if.slave  bus
);

    localparam logic [2:0] LP_LAST_LVL   = 3'(NUM_LEVELS - 1);
    localparam logic [2:0] LP_LIVES      = 3'(LIVES);
    localparam logic [9:0] LP_SPAWN_X    = 10'(SPAWN_X);
    localparam logic [9:0] LP_SPAWN_Y    = 10'(SPAWN_Y);
    localparam logic [5:0] LP_DEATH_LAST = 6'(DEATH_FRAMES - 1);
    localparam logic [5:0] LP_TRANS_LAST = 6'(TRANS_FRAMES - 1);

    typedef enum logic [6:0] {
        ST_IDLE    = 7'b0000001,
        ST_RESPAWN = 7'b0000010,
        ST_PLAY    = 7'b0000100,
        ST_DYING   = 7'b0001000,
        ST_ADVANCE = 7'b0010000,
        ST_WIN     = 7'b0100000,
        ST_OVER    = 7'b1000000
    } state_t;

    state_t     r_state;
    logic [2:0] r_level;
    logic [2:0] r_lives;
    logic [9:0] r_spawn_x;
    logic [9:0] r_spawn_y;
    logic [5:0] r_cnt;

    state_t     w_state_nxt;
    logic [2:0] w_level_nxt;
    logic [2:0] w_lives_nxt;
    logic [9:0] w_spawn_x_nxt;
    logic [9:0] w_spawn_y_nxt;
    logic [5:0] w_cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_level   <= '0;
            r_lives   <= LP_LIVES;
            r_spawn_x <= LP_SPAWN_X;
            r_spawn_y <= LP_SPAWN_Y;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_level   <= w_level_nxt;
            r_lives   <= w_lives_nxt;
            r_spawn_x <= w_spawn_x_nxt;
            r_spawn_y <= w_spawn_y_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_level_nxt   = r_level;
        w_lives_nxt   = r_lives;
        w_spawn_x_nxt = r_spawn_x;
        w_spawn_y_nxt = r_spawn_y;
        w_cnt_nxt     = r_cnt;
        case (r_state)
            ST_IDLE, ST_WIN, ST_OVER: begin
                if (bus.start) begin
                    w_state_nxt   = ST_RESPAWN;
                    w_level_nxt   = '0;
                    w_lives_nxt   = LP_LIVES;
                    w_spawn_x_nxt = LP_SPAWN_X;
                    w_spawn_y_nxt = LP_SPAWN_Y;
                    w_cnt_nxt     = '0;
                end
            end
            ST_RESPAWN: w_state_nxt = ST_PLAY;
            ST_PLAY: begin
                // Counter restarts on entry, so a tick coinciding with the hit is not counted.
                w_cnt_nxt = '0;
                if (bus.hit_exit) begin
                    w_state_nxt = (r_level == LP_LAST_LVL) ? ST_WIN : ST_ADVANCE;
                end else if (bus.hit_lava) begin
                    w_state_nxt = ST_DYING;
                    if (r_lives != 3'd0) w_lives_nxt = r_lives - 3'd1;
                end
`ifdef CHECKPOINT_EN
                else if (bus.hit_ckpt) begin
                    w_spawn_x_nxt = bus.xpos;
                    w_spawn_y_nxt = bus.ypos;
                end
`endif
            end
            ST_DYING: begin
                if (bus.tick) begin
                    if (r_cnt == LP_DEATH_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = (r_lives == 3'd0) ? ST_OVER : ST_RESPAWN;
                    end else begin
                        w_cnt_nxt = r_cnt + 6'd1;
                    end
                end
            end
            ST_ADVANCE: begin
                if (bus.tick) begin
                    if (r_cnt == LP_TRANS_LAST) begin
                        // New level always starts from the default spawn; any checkpoint is dropped.
                        w_cnt_nxt     = '0;
                        w_level_nxt   = r_level + 3'd1;
                        w_spawn_x_nxt = LP_SPAWN_X;
                        w_spawn_y_nxt = LP_SPAWN_Y;
                        w_state_nxt   = ST_RESPAWN;
                    end else begin
                        w_cnt_nxt = r_cnt + 6'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.level      = r_level;
    assign bus.lives      = r_lives;
    assign bus.freeze     = (r_state != ST_PLAY);
    assign bus.load_spawn = (r_state == ST_RESPAWN);
    assign bus.spawn_x    = r_spawn_x;
    assign bus.spawn_y    = r_spawn_y;
    assign bus.sink_ofs   = (r_state == ST_DYING) ? r_cnt : 6'd0;
    assign bus.win        = (r_state == ST_WIN);
    assign bus.game_over  = (r_state == ST_OVER);

endmodule
